// File: rtl/pong_pkg.sv
// Shared definitions for the Pong score reporter:
// command codes, FSM states, result packing.
package pong_pkg;

   localparam int unsigned SCORE_W       = 15;
   localparam int unsigned WIN_SCORE_DEF = 10;

   localparam logic [1:0] CMD_READ         = 2'b00;
   localparam logic [1:0] CMD_READ_CLR     = 2'b01;
   localparam logic [1:0] CMD_RESET_SCORES = 2'b10;

   localparam int P1_SCORE_MSB = 31;
   localparam int P1_DIRTY     = 16;
   localparam int P2_SCORE_MSB = 15;
   localparam int P2_DIRTY     = 0;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_LATCH = 2'd1,
      ST_RESP  = 2'd2
   } state_e;

   function automatic logic [31:0] pack_result(
      input logic [SCORE_W-1:0] s1,
      input logic               d1,
      input logic [SCORE_W-1:0] s2,
      input logic               d2
   );
      logic [31:0] r;
      r = '0;
      r[P1_SCORE_MSB -: SCORE_W] = s1;
      r[P1_DIRTY]                = d1;
      r[P2_SCORE_MSB -: SCORE_W] = s2;
      r[P2_DIRTY]                = d2;
      return r;
   endfunction

endpackage

// File: rtl/score_counter.sv
// Per-player saturating goal counter with a dirty flag.
// A counted goal sets dirty and overrides a dirty clear.
module score_counter
   import pong_pkg::*;
#(
   parameter int unsigned WIN_SCORE = WIN_SCORE_DEF
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic               goal_i,
   input  logic               clear_dirty_i,
   input  logic               clear_all_i,
   input  logic               freeze_i,
   output logic [SCORE_W-1:0] score_o,
   output logic               dirty_o
);

   localparam logic [SCORE_W-1:0] WIN = SCORE_W'(WIN_SCORE);

   logic [SCORE_W-1:0] score_q, score_d;
   logic               dirty_q, dirty_d;
   logic               count;

   assign count = goal_i && !freeze_i && (score_q < WIN);

   // Next state: full clear wins, then a counted goal, then dirty clear.
   always_comb begin
      score_d = score_q;
      dirty_d = dirty_q;
      if (clear_all_i) begin
         score_d = '0;
         dirty_d = 1'b0;
      end else if (count) begin
         score_d = score_q + 1'b1;
         dirty_d = 1'b1;
      end else if (clear_dirty_i) begin
         dirty_d = 1'b0;
      end
   end

   // Score and dirty registers.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         score_q <= '0;
         dirty_q <= 1'b0;
      end else begin
         score_q <= score_d;
         dirty_q <= dirty_d;
      end
   end

   assign score_o = score_q;
   assign dirty_o = dirty_q;

endmodule

// File: rtl/score_reporter.sv
// Nios II multi-cycle custom instruction returning the
// Pong score word; counts goals and answers read/clear.
module score_reporter
   import pong_pkg::*;
#(
   parameter int unsigned WIN_SCORE = WIN_SCORE_DEF
) (
   input  logic        CLK,
   input  logic        RST_BTN,
   input  logic        CLK_EN,
   input  logic        start,
   input  logic [31:0] dataa,
   input  logic        goal_p1,
   input  logic        goal_p2,
   output logic [31:0] result,
   output logic        done,
   output logic        game_over
);

   localparam logic [SCORE_W-1:0] WIN = SCORE_W'(WIN_SCORE);

   state_e             state_q;
   logic [1:0]         cmd_q;
   logic [31:0]        result_q;
   logic               done_q;
   logic               game_over_q;

   logic [SCORE_W-1:0] score1, score2;
   logic               dirty1, dirty2;
   logic               in_latch;
   logic               clr_dirty;
   logic               clr_all;
   logic               unused_dataa;

   assign unused_dataa = ^dataa[31:2];

   assign in_latch  = (state_q == ST_LATCH);
   assign clr_dirty = in_latch && (cmd_q == CMD_READ_CLR);
   assign clr_all   = in_latch && (cmd_q == CMD_RESET_SCORES);

   score_counter #(
      .WIN_SCORE     (WIN_SCORE)
   ) u_p1 (
      .clk_i         (CLK),
      .rst_i         (RST_BTN),
      .goal_i        (goal_p1),
      .clear_dirty_i (clr_dirty),
      .clear_all_i   (clr_all),
      .freeze_i      (game_over_q),
      .score_o       (score1),
      .dirty_o       (dirty1)
   );

   score_counter #(
      .WIN_SCORE     (WIN_SCORE)
   ) u_p2 (
      .clk_i         (CLK),
      .rst_i         (RST_BTN),
      .goal_i        (goal_p2),
      .clear_dirty_i (clr_dirty),
      .clear_all_i   (clr_all),
      .freeze_i      (game_over_q),
      .score_o       (score2),
      .dirty_o       (dirty2)
   );

   // Handshake FSM: capture command, snapshot, pulse done.
   always_ff @(posedge CLK or posedge RST_BTN) begin
      if (RST_BTN) begin
         state_q  <= ST_IDLE;
         cmd_q    <= CMD_READ;
         result_q <= '0;
         done_q   <= 1'b0;
      end else begin
         done_q <= 1'b0;
         unique case (state_q)
            ST_IDLE: begin
               if (start && CLK_EN) begin
                  cmd_q   <= dataa[1:0];
                  state_q <= ST_LATCH;
               end
            end
            ST_LATCH: begin
               result_q <= pack_result(score1, dirty1,
                                       score2, dirty2);
               done_q   <= 1'b1;
               state_q  <= ST_RESP;
            end
            ST_RESP: begin
               state_q <= ST_IDLE;
            end
            default: begin
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   // Win flag lags the score registers by one edge.
   always_ff @(posedge CLK or posedge RST_BTN) begin
      if (RST_BTN) begin
         game_over_q <= 1'b0;
      end else begin
         game_over_q <= (score1 == WIN) || (score2 == WIN);
      end
   end

   assign result    = result_q;
   assign done      = done_q;
   assign game_over = game_over_q;

endmodule

// File: tb/tb_score_reporter.sv
// Directed bench for score_reporter with
// hand-computed result words.
`timescale 1ns/1ps
module tb_score_reporter;

   logic        CLK = 1'b0;
   logic        RST_BTN = 1'b1;
   logic        CLK_EN = 1'b1;
   logic        start = 1'b0;
   logic [31:0] dataa = '0;
   logic        goal_p1 = 1'b0;
   logic        goal_p2 = 1'b0;
   logic [31:0] result;
   logic        done;
   logic        game_over;

   int errors = 0;
   int checks = 0;

   score_reporter #(.WIN_SCORE(10)) dut (
      .CLK       (CLK),
      .RST_BTN   (RST_BTN),
      .CLK_EN    (CLK_EN),
      .start     (start),
      .dataa     (dataa),
      .goal_p1   (goal_p1),
      .goal_p2   (goal_p2),
      .result    (result),
      .done      (done),
      .game_over (game_over)
   );

   always #5 CLK = ~CLK;

   task automatic check(input string tag,
                        input logic [31:0] got,
                        input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %08h expected %08h",
                  tag, got, exp);
      end
   endtask

   // One-cycle goal pulse(s), sampled at the next posedge.
   task automatic goal(input logic p1, input logic p2);
      @(negedge CLK);
      goal_p1 = p1;
      goal_p2 = p2;
      @(negedge CLK);
      goal_p1 = 1'b0;
      goal_p2 = 1'b0;
   endtask

   // Issue a command; lg2 pulses goal_p2 in the LATCH cycle.
   task automatic run_cmd(input logic [1:0] cmd,
                          input logic [31:0] exp,
                          input logic lg2,
                          input string tag);
      int n;
      @(negedge CLK);
      start = 1'b1;
      dataa = {30'h2AAAAAAA, cmd};
      @(posedge CLK);
      #1;
      start   = 1'b0;
      dataa   = '0;
      goal_p2 = lg2;
      n = 0;
      do begin
         @(posedge CLK);
         #1;
         goal_p2 = 1'b0;
         n++;
      end while (!done && n < 8);
      check({tag, "_lat"}, n, 1);
      check({tag, "_res"}, result, exp);
      @(posedge CLK);
      #1;
      check({tag, "_dn0"}, {31'd0, done}, 0);
   endtask

   initial begin
      #1;
      check("rst_result", result, 0);
      check("rst_done", {31'd0, done}, 0);
      check("rst_gover", {31'd0, game_over}, 0);
      @(negedge CLK);
      RST_BTN = 1'b0;

      run_cmd(2'b00, 32'h0000_0000, 1'b0, "read0");
      check("gover0", {31'd0, game_over}, 0);

      repeat (3) goal(1'b1, 1'b0);
      goal(1'b0, 1'b1);
      run_cmd(2'b11, 32'h0007_0003, 1'b0, "rd11");
      run_cmd(2'b01, 32'h0007_0003, 1'b0, "rdclr");
      run_cmd(2'b00, 32'h0006_0002, 1'b0, "rdcln");

      run_cmd(2'b10, 32'h0006_0002, 1'b0, "rst1");
      run_cmd(2'b00, 32'h0000_0000, 1'b0, "zero1");
      goal(1'b1, 1'b1);
      run_cmd(2'b00, 32'h0003_0003, 1'b0, "both");

      run_cmd(2'b10, 32'h0003_0003, 1'b0, "rst2");
      run_cmd(2'b01, 32'h0000_0000, 1'b1, "lgoal");
      run_cmd(2'b00, 32'h0000_0003, 1'b0, "lgrd");

      run_cmd(2'b10, 32'h0000_0003, 1'b0, "rst3");
      repeat (9) goal(1'b1, 1'b0);
      @(negedge CLK);
      goal_p1 = 1'b1;
      @(posedge CLK);
      #1;
      goal_p1 = 1'b0;
      check("gover_lag", {31'd0, game_over}, 0);
      @(posedge CLK);
      #1;
      check("gover_set", {31'd0, game_over}, 1);
      repeat (2) goal(1'b1, 1'b0);
      goal(1'b0, 1'b1);
      run_cmd(2'b00, 32'h0015_0000, 1'b0, "win");
      run_cmd(2'b10, 32'h0015_0000, 1'b0, "rstw");
      run_cmd(2'b00, 32'h0000_0000, 1'b0, "zero2");
      check("gover_clr", {31'd0, game_over}, 0);

      goal(1'b1, 1'b0);
      @(negedge CLK);
      start = 1'b1;
      dataa = 32'h0;
      @(posedge CLK);
      #1;
      start = 1'b0;
      @(posedge CLK);
      #1;
      check("pre_rst_dn", {31'd0, done}, 1);
      check("pre_rst_res", result, 32'h0003_0000);
      #2;
      RST_BTN = 1'b1;
      #1;
      check("arst_done", {31'd0, done}, 0);
      check("arst_res", result, 0);
      check("arst_gover", {31'd0, game_over}, 0);
      RST_BTN = 1'b0;
      run_cmd(2'b00, 32'h0000_0000, 1'b0, "post");

      $display("Result: errors=%0d of %0d checks",
               errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

endmodule

// File: doc/score_reporter.md
# score_reporter

Nios II multi-cycle custom-instruction responder that returns the Pong score to the CPU, the reverse direction of the bar-coordinate write path. It counts goals per player from one-cycle goal pulses issued by the ball logic. It keeps a dirty flag per player and answers CPU read/clear commands with a packed 32-bit result through a start/done handshake. It sits beside the VGA top level and drives the `result` word of the custom instruction.

## Interface
- `SCORE_W`, 15: score field width per player (fixed by the result packing).
- `WIN_SCORE`, 10: score at which a player wins; counting stops at this value.
- `CLK` in 1: board clock; the only clock.
- `RST_BTN` in 1: asynchronous, active-high reset.
- `CLK_EN` in 1: custom-instruction clock enable; all handshake inputs are qualified by it.
- `start` in 1: custom-instruction start, one cycle, sampled only when `CLK_EN`=1.
- `dataa` in 32: command in `dataa[1:0]`. 00 = READ, 01 = READ_CLR (read, then clear dirty flags), 10 = RESET_SCORES, 11 = treated as READ. Bits [31:2] are ignored.
- `goal_p1` in 1: one-cycle pulse, player 1 scored.
- `goal_p2` in 1: one-cycle pulse, player 2 scored.
- `result` out 32: packed as {score_p1[14:0], dirty_p1, score_p2[14:0], dirty_p2}. Bits 31:17, 16, 15:1, 0.
- `done` out 1: one-cycle pulse; `result` is valid in the same cycle.
- `game_over` out 1: high while either score equals `WIN_SCORE`.

## Operation
- FSM states:
  - IDLE: `start`&`CLK_EN` → LATCH; the command is captured.
  - LATCH: score and dirty registers are snapshotted into `result`; the command action is applied → RESP.
  - RESP: `done`=1 → IDLE.
- READ: snapshot only; no state changes.
- READ_CLR: the snapshot is taken first, then the dirty flags clear in the same LATCH edge.
- RESET_SCORES: the snapshot holds the pre-reset values. Scores and dirty flags then go to 0 and `game_over` drops.
- Goal counting, independent of the FSM:
  - `goal_pX` with score < `WIN_SCORE` increments scoreX and sets dirtyX.
  - `goal_pX` with score = `WIN_SCORE` is ignored (saturation; dirty unchanged).
  - Goals are also ignored while `game_over`=1; the other player is frozen as well.
- `goal_p1` and `goal_p2` in the same cycle: both count. If that makes both reach `WIN_SCORE`, both do.
- A goal in the LATCH cycle:
  - It is not in the snapshot, but it is counted.
  - Its dirty flag is set even under READ_CLR, because set has priority over clear.
  - Under RESET_SCORES the reset wins: the goal is lost and scores are 0.
- `start` while not IDLE is ignored; there is no queueing.
- `result` holds its last value between transactions.

## Timing
- Reset values: `result`=0, `done`=0, `game_over`=0, scores=0, dirty=0, FSM=IDLE.
- Latency: `start` sampled at edge N → `result` updated at edge N+1 → `done`=1 during cycle N+1..N+2. This is 2 cycles from `start` to `done`, constant.
- A new `start` is accepted from the cycle after `done`.
- Score increment and dirty set take effect on the edge that samples the pulse. `game_over` is registered and follows one edge later.
- `RST_BTN` mid-transaction: FSM returns to IDLE and `done` drops immediately. The transaction is lost; the CPU must not issue one while reset is held.
- Score arithmetic is unsigned `SCORE_W`-bit and never wraps (saturation at `WIN_SCORE` ≤ 2^15−1).

## Structure
- Shared package `pong_pkg`:
  - command encodings CMD_READ/CMD_READ_CLR/CMD_RESET_SCORES;
  - FSM state enum;
  - result field positions (P1_SCORE_MSB=31, P1_DIRTY=16, P2_SCORE_MSB=15, P2_DIRTY=0);
  - `SCORE_W`.
- Sub-module `score_counter`, instantiated twice: saturating counter plus dirty flag. Inputs are goal, clear_dirty, clear_all and freeze; outputs are score and dirty.

## Test plan
- Reset, then READ → `done` 2 cycles after `start`, `result`=0x00000000, `game_over`=0.
- 3× `goal_p1`, 1× `goal_p2`, then READ → `result`=0x00070003. A following READ_CLR returns 0x00070003. The next READ returns 0x00060002.
- `goal_p1` and `goal_p2` in the same cycle from 0/0 → READ gives 0x00030003.
- `goal_p2` asserted in the LATCH cycle of READ_CLR from 0/0 → snapshot 0x00000000. A subsequent READ gives 0x00000003.
- 12× `goal_p1` with `WIN_SCORE`=10 → score_p1 stops at 10 and `game_over`=1. `goal_p2` is then ignored and READ gives 0x00150000. RESET_SCORES returns 0x00150000, then READ gives 0 and `game_over`=0.
- `RST_BTN` pulsed in the RESP cycle → `done` drops asynchronously and all outputs are 0. The next READ completes normally.
